// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus a start/busy/done burst engine
// that shifts or rotates the word one position per clock in one of five modes.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ASR = 3'd4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] shift_q;
  logic             shift_out;

  always_comb begin
    shift_q   = q;
    shift_out = sout;
    case (op_q)
      OP_SHL: begin shift_q = {q[WIDTH-2:0], sin};      shift_out = q[WIDTH-1]; end
      OP_SHR: begin shift_q = {sin, q[WIDTH-1:1]};      shift_out = q[0];       end
      OP_ROL: begin shift_q = {q[WIDTH-2:0], q[WIDTH-1]}; shift_out = q[WIDTH-1]; end
      OP_ROR: begin shift_q = {q[0], q[WIDTH-1:1]};     shift_out = q[0];       end
      OP_ASR: begin shift_q = {q[WIDTH-1], q[WIDTH-1:1]}; shift_out = q[0];     end
      default: ;
    endcase
  end

  // count holds the shifts still to do; the edge that consumes the last one
  // (or the first RUN edge when amt was zero) returns to IDLE and pulses done
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      q     <= '0;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      op_q  <= 3'd0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q     <= d;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (op <= OP_ASR)) begin
              op_q  <= op;
              count <= amt;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (count != '0) begin
              q     <= shift_q;
              sout  <= shift_out;
              count <= count - AMT_W'(1);
            end
            if (count <= AMT_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised self-checking bench for univ_shift_reg; expected values come from
// an arithmetic model of each shift mode kept in the bench.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load = 1'b0;
  logic [7:0] d = '0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] amt = '0;
  logic       sin = 1'b0;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0] mq = '0;
  logic       msout = 1'b0;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .clr(clr), .load(load), .d(d), .start(start), .op(op),
    .amt(amt), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One step of each mode computed with plain integer arithmetic on the value
  function automatic int model_step(input int o, input int v, input int s, output int so);
    case (o)
      0: begin so = v / 128; return (v * 2) % 256 + s; end
      1: begin so = v % 2;   return v / 2 + s * 128; end
      2: begin so = v / 128; return (v * 2) % 256 + v / 128; end
      3: begin so = v % 2;   return v / 2 + (v % 2) * 128; end
      default: begin so = v % 2; return v / 2 + (v / 128) * 128; end
    endcase
  endfunction

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    d = v;
    tick();
    load = 1'b0;
    mq = v;
    nCompared++;
    if (q !== mq || busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL load: q=%h busy=%b done=%b, required q=%h busy=0 done=0", q, busy, done, mq);
    end
  endtask

  // sinMode: 0/1 fixed fill bit, 2 random; noisy keeps start high and op/amt moving during RUN
  task automatic run_burst(input int o, input int n, input int sinMode, input bit noisy, input string tag);
    int so;
    int nv;
    start = 1'b1;
    op = 3'(o);
    amt = 4'(n);
    tick();
    start = noisy;
    op = 3'($urandom);
    amt = 4'($urandom);
    nCompared++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== mq) begin
      nMismatched++;
      $display("[TB] FAIL %s accept: busy=%b done=%b q=%h, required busy=1 done=0 q=%h", tag, busy, done, q, mq);
    end
    if (n == 0) begin
      start = 1'b0;
      tick();
      nCompared++;
      if (busy !== 1'b0 || done !== 1'b1 || q !== mq || sout !== msout) begin
        nMismatched++;
        $display("[TB] FAIL %s amt0: busy=%b done=%b q=%h sout=%b, required busy=0 done=1 q=%h sout=%b",
                 tag, busy, done, q, sout, mq, msout);
      end
    end else begin
      for (int i = 1; i <= n; i++) begin
        sin = (sinMode == 2) ? 1'($urandom_range(0, 1)) : 1'(sinMode);
        if (noisy) begin
          op = 3'($urandom);
          amt = 4'($urandom);
        end
        tick();
        nv = model_step(o, int'(mq), int'(sin), so);
        mq = 8'(nv);
        msout = 1'(so);
        nCompared++;
        if (q !== mq || sout !== msout || busy !== (i < n) || done !== (i == n)) begin
          nMismatched++;
          $display("[TB] FAIL %s step%0d: q=%h sout=%b busy=%b done=%b, required q=%h sout=%b busy=%b done=%b",
                   tag, i, q, sout, busy, done, mq, msout, i < n, i == n);
        end
      end
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 clr = 1'b0;
    #1;
    nCompared++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset: q=%h busy=%b done=%b sout=%b, required all zero", q, busy, done, sout);
    end
    tick();
    clr = 1'b1;
    mq = 8'h00;
    msout = 1'b0;
  endtask

  task automatic test_load();
    do_load(8'hA5);
    nCompared++;
    if (q !== 8'hA5) begin
      nMismatched++;
      $display("[TB] FAIL load_a5: q=%h, required a5", q);
    end
  endtask

  task automatic test_rol();
    do_load(8'h81);
    run_burst(2, 3, 2, 1'b0, "rol3");
    tick();
    nCompared++;
    if (q !== 8'h0C || sout !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rol3_end: q=%h sout=%b done=%b, required q=0c sout=0 done=0", q, sout, done);
    end
  endtask

  task automatic test_asr_shr();
    logic [7:0] want [3] = '{8'hE4, 8'hE4, 8'h24};
    int ops [3] = '{4, 1, 1};
    int sins [3] = '{2, 1, 0};
    for (int k = 0; k < 3; k++) begin
      do_load(8'h90);
      run_burst(ops[k], 2, sins[k], 1'b0, "asr_shr");
      nCompared++;
      if (q !== want[k] || sout !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL asr_shr%0d: q=%h sout=%b, required q=%h sout=0", k, q, sout, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int so;
    do_load(8'h0F);
    start = 1'b1;
    op = 3'd0;
    amt = 4'd5;
    tick();
    start = 1'b0;
    sin = 1'($urandom_range(0, 1));
    tick();
    mq = 8'(model_step(0, int'(mq), int'(sin), so));
    msout = 1'(so);
    load = 1'b1;
    d = 8'h3C;
    tick();
    load = 1'b0;
    nCompared++;
    if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0 || sout !== msout) begin
      nMismatched++;
      $display("[TB] FAIL abort: q=%h busy=%b done=%b sout=%b, required q=3c busy=0 done=0 sout=%b",
               q, busy, done, sout, msout);
    end
    mq = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      nCompared++;
      if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL abort_after%0d: q=%h busy=%b done=%b, required q=3c busy=0 done=0", i, q, busy, done);
      end
    end
  endtask

  task automatic test_busy_ignore();
    do_load(8'($urandom));
    run_burst(3, 4, 2, 1'b1, "busy_ignore");
    tick();
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== mq) begin
      nMismatched++;
      $display("[TB] FAIL busy_ignore_end: busy=%b done=%b q=%h, required busy=0 done=0 q=%h", busy, done, q, mq);
    end
  endtask

  task automatic test_boundary();
    do_load(8'h6B);
    run_burst(int'($urandom_range(0, 4)), 0, 2, 1'b0, "amt0");
    nCompared++;
    if (q !== 8'h6B) begin
      nMismatched++;
      $display("[TB] FAIL amt0_q: q=%h, required 6b", q);
    end
    tick();
    do_load(8'h5A);
    run_burst(2, 8, 2, 1'b0, "rol8");
    nCompared++;
    if (q !== 8'h5A) begin
      nMismatched++;
      $display("[TB] FAIL rol8_q: q=%h, required 5a", q);
    end
    tick();
    do_load(8'h12);
    run_burst(0, 15, 1, 1'b0, "shl15");
    nCompared++;
    if (q !== 8'hFF) begin
      nMismatched++;
      $display("[TB] FAIL shl15_q: q=%h, required ff", q);
    end
    tick();
  endtask

  task automatic test_reserved();
    for (int r = 5; r <= 7; r++) begin
      do_load(8'h66);
      start = 1'b1;
      op = 3'(r);
      amt = 4'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h66) begin
          nMismatched++;
          $display("[TB] FAIL reserved%0d_%0d: busy=%b done=%b q=%h, required busy=0 done=0 q=66", r, i, busy, done, q);
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    do_load(8'hC3);
    run_burst(0, 3, 2, 1'b0, "b2b_first");
    run_burst(1, 2, 2, 1'b0, "b2b_second");
    run_burst(4, 0, 2, 1'b0, "b2b_third");
    tick();
  endtask

  task automatic test_async_reset();
    do_load(8'hF7);
    start = 1'b1;
    op = 3'd2;
    amt = 4'd9;
    tick();
    start = 1'b0;
    tick();
    #2 clr = 1'b0;
    #1;
    nCompared++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL async_clr: q=%h busy=%b done=%b sout=%b, required all zero", q, busy, done, sout);
    end
    mq = 8'h00;
    msout = 1'b0;
    tick();
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL post_clr%0d: q=%h busy=%b done=%b, required q=00 busy=0 done=0", i, q, busy, done);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 2) == 0) do_load(8'($urandom));
      run_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)), "random");
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_rol();
    test_asr_shr();
    test_abort();
    test_busy_ignore();
    test_boundary();
    test_reserved();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
